mem_responder: RTL and testbench

- Memory-side responder for the processor's multi-cycle datapath. It is the device that generates the control unit's external ready input.
- Accepts one word read or write per handshake: address from MAR, write data from MOR, read data returned to MDR.
- Models a single-port word RAM with a configurable number of wait states.
- Sits between the datapath memory registers and on-chip storage; one outstanding request at a time.

---
 rtl/mem_resp_pkg.sv | 19 +
 rtl/mem_resp_ram.sv | 46 ++++
 rtl/mem_responder.sv | 130 +++++++++++++
 tb/tb_mem_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and constants for the memory responder.
//   state_t    : responder FSM states (2-bit encoding)
//   WORD_BYTES : bytes per RAM word
//   BE_W       : byte-enable width
//   CNT_W      : wait-state counter width (covers 0..15)
package mem_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int BE_W       = 4;
    localparam int CNT_W      = 4;

endpackage

// File: rtl/mem_resp_ram.sv
// mem_resp_ram: synchronous single-port word RAM with byte enables.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset; clears the read register and
//           blocks any write presented in the same cycle
//   en    : access strobe (one cycle)
//   we    : 1 = write the enabled bytes, 0 = read into rdata
//   be    : byte enables, bit n covers wdata[8n+7:8n]
//   addr  : word index
//   wdata : write data
//   rdata : registered read data, updated only by reads, held otherwise
// Storage itself is never reset.
module mem_resp_ram
    import mem_resp_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [BE_W-1:0]       be,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst && en && we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)            rdata <= '0;
        else if (en && !we) rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multi-cycle datapath.
// One word read/write per handshake, WAIT_CYCLES wait states, then one
// access cycle, then a single-cycle oRdy pulse.
// Ports:
//   iClk, iRst     : clock; synchronous active-high reset
//   iReq, iWE      : request strobe (sampled in IDLE), write select
//   iAddr, iWData  : byte address (MAR), write data (MOR)
//   iBE            : write byte enables
//   oRdy           : completion pulse (one cycle, in DONE)
//   oRData         : read data (MDR), held between reads
//   oBusy          : high whenever not IDLE
//   oFault         : misalignment fault, qualified by oRdy
// Build option: define MEM_ALIGN_CHECK_EN to flag requests with
// iAddr[1:0] != 0; such requests keep their timing but touch neither the
// RAM nor oRData. Without it oFault is constant 0.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iReq,
    input  logic              iWE,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic [DATA_W-1:0] iWData,
    input  logic [BE_W-1:0]   iBE,
    output logic              oRdy,
    output logic [DATA_W-1:0] oRData,
    output logic              oBusy,
    output logic              oFault
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    state_t                  state;
    logic [CNT_W-1:0]        wait_cnt;
    logic                    req_we;
    logic [DEPTH_LOG2-1:0]   req_idx;
    logic [DATA_W-1:0]       req_wdata;
    logic [BE_W-1:0]         req_be;
    logic                    access_en;
    logic                    capture;

    assign capture = (state == ST_IDLE) && iReq;
    assign oBusy   = (state != ST_IDLE);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            oRdy      <= 1'b0;
            req_we    <= 1'b0;
            req_idx   <= '0;
            req_wdata <= '0;
            req_be    <= '0;
        end else begin
            oRdy <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iReq) begin
                        req_we    <= iWE;
                        req_idx   <= iAddr[DEPTH_LOG2+1:2];
                        req_wdata <= iWData;
                        req_be    <= iBE;
                        wait_cnt  <= WAIT_INIT;
                        state     <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
                    end
                end
                ST_WAIT: begin
                    // Counter starts at WAIT_CYCLES, so WAIT lasts exactly
                    // that many cycles.
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt <= 1) state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // oRdy is registered here so it is high for the DONE cycle.
                    state <= ST_DONE;
                    oRdy  <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic req_misalign;
    logic fault_q;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            req_misalign <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            if (capture) req_misalign <= |iAddr[1:0];
            fault_q <= (state == ST_ACCESS) && req_misalign;
        end
    end

    assign access_en = (state == ST_ACCESS) && !req_misalign;
    assign oFault    = fault_q;
`else
    logic unused_lo;
    assign unused_lo = ^{iAddr[1:0], capture};
    assign access_en = (state == ST_ACCESS);
    assign oFault    = 1'b0;
`endif

    // Address bits above the RAM index alias onto the same words.
    logic unused_hi;
    assign unused_hi = ^iAddr[ADDR_W-1:DEPTH_LOG2+2];

    mem_resp_ram #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (iClk),
        .rst   (iRst),
        .en    (access_en),
        .we    (req_we),
        .be    (req_be),
        .addr  (req_idx),
        .wdata (req_wdata),
        .rdata (oRData)
    );

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed plus randomized checks of mem_responder.
// Two instances share clock and reset: u0 with two wait states, u1 with
// none. Expected data comes from a word-array memory model per instance.
module tb_mem_responder;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req = '0;
    logic [1:0]       we  = '0;
    logic [1:0][31:0] addr  = '0;
    logic [1:0][31:0] wdata = '0;
    logic [1:0][3:0]  be    = '0;
    logic [1:0]       rdy, busy, fault;
    logic [1:0][31:0] rdata;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [31:0] mem_m [2][1024];
    logic [31:0] rd_m  [2];
    int          wait_m [2] = '{2, 0};
    int          idxs [8];

    always #5 clk = ~clk;

    mem_responder #(.WAIT_CYCLES(2)) u0 (
        .iClk(clk), .iRst(rst), .iReq(req[0]), .iWE(we[0]), .iAddr(addr[0]),
        .iWData(wdata[0]), .iBE(be[0]), .oRdy(rdy[0]), .oRData(rdata[0]),
        .oBusy(busy[0]), .oFault(fault[0])
    );

    mem_responder #(.WAIT_CYCLES(0)) u1 (
        .iClk(clk), .iRst(rst), .iReq(req[1]), .iWE(we[1]), .iAddr(addr[1]),
        .iWData(wdata[1]), .iBE(be[1]), .oRdy(rdy[1]), .oRData(rdata[1]),
        .oBusy(busy[1]), .oFault(fault[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: a word memory indexed by byte address / 4 modulo 1024.
    task automatic model_apply(input int d, input logic w, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] b,
                               output logic [31:0] exp_rd, output logic exp_f);
        int  idx;
        bit  mis;
        logic [31:0] word;
        idx = (a / 4) % 1024;
        mis = ALIGN && (a % 4 != 0);
        if (!mis) begin
            if (w) begin
                word = mem_m[d][idx];
                for (int k = 0; k < 4; k++)
                    if (b[k]) word[8*k +: 8] = wd[8*k +: 8];
                mem_m[d][idx] = word;
            end else begin
                rd_m[d] = mem_m[d][idx];
            end
        end
        exp_rd = rd_m[d];
        exp_f  = mis;
    endtask

    task automatic xact(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b, input string tag);
        logic [31:0] er;
        logic        ef;
        int          lat;
        bit          got;
        model_apply(d, w, a, wd, b, er, ef);
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
        @(posedge clk);
        lat = 0; got = 0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check({tag, " busy"}, 32'(busy[d]), 32'd1);
            if (rdy[d]) got = 1;
        end
        req[d] = 1'b0; addr[d] = $urandom(); wdata[d] = $urandom();
        check({tag, " latency"}, 32'(lat), 32'(wait_m[d] + 2));
        check({tag, " rdata"}, rdata[d], er);
        check({tag, " fault"}, 32'(fault[d]), 32'(ef));
        @(negedge clk);
        check({tag, " rdy pulse width"}, 32'(rdy[d]), 32'd0);
    endtask

    // Full-word write interrupted by reset k negedges after the request edge.
    task automatic xact_rst(input int d, input logic [31:0] a, input logic [31:0] wd,
                            input int k, input string tag);
        bit seen;
        @(negedge clk);
        req[d] = 1'b1; we[d] = 1'b1; addr[d] = a; wdata[d] = wd; be[d] = 4'hF;
        @(posedge clk);
        repeat (k) @(negedge clk);
        rst = 1'b1; req[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rd_m[0] = '0; rd_m[1] = '0;
        check({tag, " busy after reset"}, 32'(busy[d]), 32'd0);
        check({tag, " rdata after reset"}, rdata[d], 32'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rdy[d]) seen = 1;
        end
        check({tag, " no rdy"}, 32'(seen), 32'd0);
    endtask

    initial begin
        rd_m[0] = '0; rd_m[1] = '0;

        // Reset then idle.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            for (int d = 0; d < 2; d++) begin
                check("idle rdy",   32'(rdy[d]),   32'd0);
                check("idle busy",  32'(busy[d]),  32'd0);
                check("idle fault", 32'(fault[d]), 32'd0);
                check("idle rdata", rdata[d],      32'd0);
            end
            @(negedge clk);
        end

        // Write/read, two wait states.
        xact(0, 1, 32'h40, 32'hDEADBEEF, 4'hF, "wr 0x40");
        xact(0, 0, 32'h40, 32'h0,        4'hF, "rd 0x40");
        check("rd 0x40 literal", rdata[0], 32'hDEADBEEF);

        // Byte-enable merge.
        xact(0, 1, 32'h80, 32'h11223344, 4'hF,    "wr 0x80 full");
        xact(0, 1, 32'h80, 32'hAABBCCDD, 4'b0101, "wr 0x80 be5");
        xact(0, 0, 32'h80, 32'h0,        4'hF,    "rd 0x80");
        check("be merge literal", rdata[0], 32'h11BB33DD);
        xact(0, 1, 32'h80, 32'h99999999, 4'h0,    "wr 0x80 be0");
        xact(0, 0, 32'h80, 32'h0,        4'hF,    "rd 0x80 after be0");

        // Aliasing, zero wait states.
        xact(1, 1, 32'h0,    32'h5, 4'hF, "z wr 0x0");
        xact(1, 0, 32'h1000, 32'h0, 4'hF, "z rd 0x1000");
        check("alias literal", rdata[1], 32'h5);

        // Reset mid-operation.
        xact(0, 1, 32'h10, 32'h0, 4'hF, "wr 0x10 zero");
        xact_rst(0, 32'h10, 32'hFFFFFFFF, 1, "rst in wait");
        xact(0, 0, 32'h10, 32'h0, 4'hF, "rd 0x10 after rst");
        xact(0, 1, 32'h14, 32'h12345678, 4'hF, "wr 0x14");
        xact_rst(0, 32'h14, 32'h0, 3, "rst in access");
        xact(0, 0, 32'h14, 32'h0, 4'hF, "rd 0x14 after rst");
        xact(1, 1, 32'h24, 32'h87654321, 4'hF, "z wr 0x24");
        xact_rst(1, 32'h24, 32'h0, 1, "z rst in access");
        xact(1, 0, 32'h24, 32'h0, 4'hF, "z rd 0x24 after rst");

        // Misaligned write: faults and is dropped only with the check built in.
        xact(0, 1, 32'h42, 32'hCAFEF00D, 4'hF, "wr 0x42");
        xact(0, 0, 32'h40, 32'h0,        4'hF, "rd 0x40 after 0x42");
        xact(0, 0, 32'h43, 32'h0,        4'hF, "rd 0x43");

        // Randomized traffic over a set of pre-initialised words.
        for (int i = 0; i < 8; i++) idxs[i] = 100 + 37 * i;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++)
                xact(d, 1, 32'(idxs[i] * 4), $urandom(), 4'hF, "rnd init");
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            int          d;
            a = $urandom();
            a[11:2] = 10'(idxs[$urandom_range(7)]);
            a[1:0]  = ($urandom_range(3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            d = $urandom_range(1);
            xact(d, 1'($urandom_range(1)), a, $urandom(), 4'($urandom_range(15)), "rnd");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
